// File: rtl/dual_issue_scheduler.sv
// Two-slot in-order issue scheduler with a 128-entry countdown scoreboard.
// Holds one decoded pair and dual-issues it to the even/odd pipes.
module dual_issue_scheduler (
    input  logic       clk,
    input  logic       reset,
    input  logic       pair_valid,
    output logic       pair_ready,
    input  logic       slot1_valid,
    input  logic       flush,
    input  logic       slot0_pipe,
    input  logic       slot0_wen,
    input  logic [6:0] slot0_rt,
    input  logic [6:0] slot0_ra,
    input  logic [6:0] slot0_rb,
    input  logic [6:0] slot0_rc,
    input  logic [2:0] slot0_srcuse,
    input  logic [2:0] slot0_latency,
    input  logic       slot1_pipe,
    input  logic       slot1_wen,
    input  logic [6:0] slot1_rt,
    input  logic [6:0] slot1_ra,
    input  logic [6:0] slot1_rb,
    input  logic [6:0] slot1_rc,
    input  logic [2:0] slot1_srcuse,
    input  logic [2:0] slot1_latency,
    output logic       issue_even_valid,
    output logic       issue_even_sel,
    output logic       issue_odd_valid,
    output logic       issue_odd_sel,
    output logic       stall
);

    typedef struct packed {
        logic       pipe;
        logic       wen;
        logic [6:0] rt;
        logic [6:0] ra;
        logic [6:0] rb;
        logic [6:0] rc;
        logic [2:0] srcUse;
        logic [2:0] latency;
    } slotT;

    localparam logic [1:0] EMPTY  = 2'd0;
    localparam logic [1:0] PAIR   = 2'd1;
    localparam logic [1:0] SECOND = 2'd2;

    logic [1:0] state;
    slotT       hold0;
    slotT       hold1;
    logic       holdS1Valid;
    slotT       inSlot0;
    slotT       inSlot1;
    logic [2:0] sb     [128];
    logic [2:0] sbNext [128];

    logic       act;
    logic       ready0;
    logic       ready1;
    logic       rawHit;
    logic       wawHit;
    logic       iss0;
    logic       dual;
    logic       issSec;
    logic       iss1;
    logic       drain;
    logic       pairReady;
    logic       evenValid;
    logic       oddValid;
    logic [2:0] load0;
    logic [2:0] load1;

    function automatic logic [2:0] latMinus1(input logic [2:0] lat);
        return (lat == 3'd0) ? 3'd0 : lat - 3'd1;
    endfunction

    assign inSlot0 = {slot0_pipe, slot0_wen, slot0_rt, slot0_ra,
                      slot0_rb, slot0_rc, slot0_srcuse, slot0_latency};
    assign inSlot1 = {slot1_pipe, slot1_wen, slot1_rt, slot1_ra,
                      slot1_rb, slot1_rc, slot1_srcuse, slot1_latency};

    assign act = reset & ~flush;

    assign ready0 = (~hold0.srcUse[0] | (sb[hold0.ra] == 3'd0))
                  & (~hold0.srcUse[1] | (sb[hold0.rb] == 3'd0))
                  & (~hold0.srcUse[2] | (sb[hold0.rc] == 3'd0));
    assign ready1 = (~hold1.srcUse[0] | (sb[hold1.ra] == 3'd0))
                  & (~hold1.srcUse[1] | (sb[hold1.rb] == 3'd0))
                  & (~hold1.srcUse[2] | (sb[hold1.rc] == 3'd0));

    // Slot 1 may not consume or overwrite slot 0's result in the same cycle
    assign rawHit = hold0.wen
                  & ((hold1.srcUse[0] & (hold1.ra == hold0.rt))
                   | (hold1.srcUse[1] & (hold1.rb == hold0.rt))
                   | (hold1.srcUse[2] & (hold1.rc == hold0.rt)));
    assign wawHit = hold0.wen & hold1.wen & (hold0.rt == hold1.rt);

    assign iss0   = act & (state == PAIR) & ready0;
    assign dual   = iss0 & holdS1Valid & (hold1.pipe != hold0.pipe)
                  & ready1 & ~rawHit & ~wawHit;
    assign issSec = act & (state == SECOND) & ready1;
    assign iss1   = dual | issSec;
    assign drain  = (iss0 & (~holdS1Valid | dual)) | issSec;

    assign pairReady = act & ((state == EMPTY) | drain);
    assign evenValid = (iss0 & ~hold0.pipe) | (iss1 & ~hold1.pipe);
    assign oddValid  = (iss0 & hold0.pipe) | (iss1 & hold1.pipe);

    assign pair_ready       = pairReady;
    assign issue_even_valid = evenValid;
    assign issue_even_sel   = iss1 & ~hold1.pipe;
    assign issue_odd_valid  = oddValid;
    assign issue_odd_sel    = iss1 & hold1.pipe;
    assign stall = act & (state != EMPTY) & ~evenValid & ~oddValid;

    assign load0 = latMinus1(hold0.latency);
    assign load1 = latMinus1(hold1.latency);

    // A new write never shortens an older, longer pending write to the same rt
    always_comb begin
        for (int i = 0; i < 128; i++) begin
            sbNext[i] = (sb[i] == 3'd0) ? 3'd0 : sb[i] - 3'd1;
            if (iss0 && hold0.wen && hold0.rt == 7'(i) && load0 > sbNext[i])
                sbNext[i] = load0;
            if (iss1 && hold1.wen && hold1.rt == 7'(i) && load1 > sbNext[i])
                sbNext[i] = load1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 128; i++) begin
            sb[i] <= reset ? sbNext[i] : 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= EMPTY;
            hold0       <= '0;
            hold1       <= '0;
            holdS1Valid <= 1'b0;
        end else if (flush) begin
            state <= EMPTY;
        end else if (pair_valid && pairReady) begin
            state       <= PAIR;
            hold0       <= inSlot0;
            hold1       <= inSlot1;
            holdS1Valid <= slot1_valid;
        end else if (iss0) begin
            state <= (holdS1Valid && !dual) ? SECOND : EMPTY;
        end else if (issSec) begin
            state <= EMPTY;
        end
    end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed table-driven bench for dual_issue_scheduler.
// Each table row is one clock cycle of inputs and expected outputs.
module tb_dual_issue_scheduler;

    typedef struct packed {
        logic       pipe;
        logic       wen;
        logic [6:0] rt;
        logic [6:0] ra;
        logic [6:0] rb;
        logic [6:0] rc;
        logic [2:0] srcUse;
        logic [2:0] lat;
    } slotT;

    typedef struct {
        string      name;
        logic       rst;
        logic       pv;
        logic       s1v;
        logic       fl;
        slotT       s0;
        slotT       s1;
        logic [5:0] exp;
    } vecT;

    logic clk;
    logic reset;
    logic pair_valid;
    logic pair_ready;
    logic slot1_valid;
    logic flush;
    slotT s0;
    slotT s1;
    logic issue_even_valid;
    logic issue_even_sel;
    logic issue_odd_valid;
    logic issue_odd_sel;
    logic stall;

    int checks = 0;
    int errors = 0;
    vecT vecs[$];

    dual_issue_scheduler dut (
        .clk(clk),
        .reset(reset),
        .pair_valid(pair_valid),
        .pair_ready(pair_ready),
        .slot1_valid(slot1_valid),
        .flush(flush),
        .slot0_pipe(s0.pipe),
        .slot0_wen(s0.wen),
        .slot0_rt(s0.rt),
        .slot0_ra(s0.ra),
        .slot0_rb(s0.rb),
        .slot0_rc(s0.rc),
        .slot0_srcuse(s0.srcUse),
        .slot0_latency(s0.lat),
        .slot1_pipe(s1.pipe),
        .slot1_wen(s1.wen),
        .slot1_rt(s1.rt),
        .slot1_ra(s1.ra),
        .slot1_rb(s1.rb),
        .slot1_rc(s1.rc),
        .slot1_srcuse(s1.srcUse),
        .slot1_latency(s1.lat),
        .issue_even_valid(issue_even_valid),
        .issue_even_sel(issue_even_sel),
        .issue_odd_valid(issue_odd_valid),
        .issue_odd_sel(issue_odd_sel),
        .stall(stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic slotT mk(input logic p, input logic w,
                                input logic [6:0] rt, input logic [6:0] ra,
                                input logic [6:0] rb, input logic [6:0] rc,
                                input logic [2:0] u, input logic [2:0] l);
        return {p, w, rt, ra, rb, rc, u, l};
    endfunction

    task automatic add(input string n, input logic r, input logic pv,
                       input logic sv, input logic fl, input slotT a,
                       input slotT b, input logic [5:0] e);
        vecT v;
        v.name = n; v.rst = r; v.pv = pv; v.s1v = sv; v.fl = fl;
        v.s0 = a; v.s1 = b; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic pv, input logic sv,
                         input logic fl, input slotT a, input slotT b);
        @(negedge clk);
        reset = r; pair_valid = pv; slot1_valid = sv; flush = fl;
        s0 = a; s1 = b;
        #2;
    endtask

    function automatic logic [5:0] outs();
        return {pair_ready, issue_even_valid, issue_even_sel,
                issue_odd_valid, issue_odd_sel, stall};
    endfunction

    task automatic check(input string n, input logic [5:0] got,
                         input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b (rdy,eV,eS,oV,oS,stall)",
                     n, got, exp);
        end
    endtask

    initial begin
        slotT z, a, b, c, d, e, f, g, h, i, j, k, p, q, r, s, t, u;
        int found;
        int stalls;
        z = '0;
        // Independent pair: even rt5 L2, odd rt6 L4
        a = mk(0, 1, 5, 0, 0, 0, 3'b000, 2);
        b = mk(1, 1, 6, 0, 0, 0, 3'b000, 4);
        // Same pipe pair
        c = mk(0, 1, 20, 0, 0, 0, 3'b000, 1);
        d = mk(0, 1, 21, 0, 0, 0, 3'b000, 1);
        // Intra-pair RAW: rt10 L6 -> RA=10
        e = mk(0, 1, 10, 0, 0, 0, 3'b000, 6);
        f = mk(1, 0, 0, 10, 0, 0, 3'b001, 1);
        // Cross-pair RAW L=1 on r3 through RB
        g = mk(0, 1, 3, 0, 0, 0, 3'b000, 1);
        h = mk(0, 0, 0, 0, 3, 0, 3'b010, 1);
        // Flush case: rt12 L5, consumer reads RC=12
        i = mk(0, 1, 12, 0, 0, 0, 3'b000, 5);
        j = mk(1, 1, 13, 0, 0, 12, 3'b100, 3);
        k = mk(0, 0, 0, 0, 0, 12, 3'b100, 1);
        // Reset case: r7 producer L6, consumer on RA
        p = mk(0, 1, 7, 0, 0, 0, 3'b000, 6);
        q = mk(0, 0, 0, 7, 0, 0, 3'b001, 1);
        // WAW on r30, slot 0 latency 0
        r = mk(0, 1, 30, 0, 0, 0, 3'b000, 0);
        s = mk(1, 1, 30, 0, 0, 0, 3'b000, 1);
        // Intra-pair RAW at L=7
        t = mk(0, 1, 40, 0, 0, 0, 3'b000, 7);
        u = mk(1, 0, 0, 40, 0, 0, 3'b001, 1);

        add("rstHeld",    0, 1, 1, 0, a, b, 6'b000000);
        add("rstRelease", 1, 0, 0, 0, z, z, 6'b100000);
        add("indLoad",    1, 1, 1, 0, a, b, 6'b100000);
        add("indDual",    1, 0, 0, 0, z, z, 6'b110110);
        add("indEmpty",   1, 0, 0, 0, z, z, 6'b100000);
        add("spLoad",     1, 1, 1, 0, c, d, 6'b100000);
        add("spSlot0",    1, 0, 0, 0, z, z, 6'b010000);
        add("spSlot1",    1, 0, 0, 0, z, z, 6'b111000);
        add("spEmpty",    1, 0, 0, 0, z, z, 6'b100000);
        add("rawLoad",    1, 1, 1, 0, e, f, 6'b100000);
        add("rawSlot0",   1, 0, 0, 0, z, z, 6'b010000);
        for (int n = 1; n <= 5; n++)
            add($sformatf("rawStall%0d", n), 1, 0, 0, 0, z, z, 6'b000001);
        add("rawSlot1",   1, 0, 0, 0, z, z, 6'b100110);
        add("rawEmpty",   1, 0, 0, 0, z, z, 6'b100000);
        add("xLoadProd",  1, 1, 0, 0, g, z, 6'b100000);
        add("xProdNext",  1, 1, 0, 0, h, z, 6'b110000);
        add("xConsumer",  1, 0, 0, 0, z, z, 6'b110000);
        add("xEmpty",     1, 0, 0, 0, z, z, 6'b100000);
        add("flLoad",     1, 1, 1, 0, i, j, 6'b100000);
        add("flSlot0",    1, 0, 0, 0, z, z, 6'b010000);
        add("flBlocked",  1, 0, 0, 0, z, z, 6'b000001);
        add("flFlush",    1, 1, 1, 1, i, j, 6'b000000);
        add("flEmpty",    1, 1, 0, 0, k, z, 6'b100000);
        add("flCntWait",  1, 0, 0, 0, z, z, 6'b000001);
        add("flCntDone",  1, 0, 0, 0, z, z, 6'b110000);
        add("flIdle",     1, 0, 0, 0, z, z, 6'b100000);
        add("rsLoadProd", 1, 1, 0, 0, p, z, 6'b100000);
        add("rsProd",     1, 1, 0, 0, q, z, 6'b110000);
        add("rsBlocked",  1, 0, 0, 0, z, z, 6'b000001);
        add("rsInPair",   0, 0, 0, 0, z, z, 6'b000000);
        add("rsDropped",  1, 1, 0, 0, q, z, 6'b100000);
        add("rsConsumer", 1, 0, 0, 0, z, z, 6'b110000);
        add("rsEmpty",    1, 0, 0, 0, z, z, 6'b100000);
        add("wawLoad",    1, 1, 1, 0, r, s, 6'b100000);
        add("wawSlot0",   1, 0, 0, 0, z, z, 6'b010000);
        add("wawSlot1",   1, 0, 0, 0, z, z, 6'b100110);
        add("wawEmpty",   1, 0, 0, 0, z, z, 6'b100000);

        reset = 1'b0; pair_valid = 1'b0; slot1_valid = 1'b0;
        flush = 1'b0; s0 = z; s1 = z;

        foreach (vecs[n]) begin
            drive(vecs[n].rst, vecs[n].pv, vecs[n].s1v, vecs[n].fl,
                  vecs[n].s0, vecs[n].s1);
            check(vecs[n].name, outs(), vecs[n].exp);
        end

        // L=7 dependant: bounded wait for the odd issue
        drive(1, 1, 1, 0, t, u);
        check("l7Load", outs(), 6'b100000);
        drive(1, 0, 0, 0, z, z);
        check("l7Slot0", outs(), 6'b010000);
        found = 0;
        stalls = 0;
        for (int n = 1; n <= 20 && found == 0; n++) begin
            drive(1, 0, 0, 0, z, z);
            if (issue_odd_valid) found = n;
            else if (stall) stalls++;
        end
        check("l7Latency", 6'(found), 6'd7);
        check("l7Stalls", 6'(stalls), 6'd6);
        drive(1, 0, 0, 0, z, z);
        check("l7Empty", outs(), 6'b100000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dual_issue_scheduler.md
DUAL_ISSUE_SCHEDULER -- requirements
Module: dual_issue_scheduler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk samples everything on its rising edge, and reset is sampled on that same edge.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  pipeline clock
- reset  in  1  synchronous active-low reset
- pair_valid  in  1  decode offers an instruction pair
- pair_ready  out  1  scheduler accepts the pair this cycle
- slot1_valid  in  1  slot 1 holds an instruction (slot 0 is always valid when pair_valid)
- flush  in  1  branch mispredict: discard held instructions
- slotN_pipe  in  1  target pipe, 0=even, 1=odd (N=0,1)
- slotN_wen  in  1  instruction writes RT
- slotN_rt  in  7  destination register
- slotN_ra, slotN_rb, slotN_rc  in  7 each  source registers
- slotN_srcuse  in  3  bit0=RA, bit1=RB, bit2=RC is read
- slotN_latency  in  3  producer latency in cycles (0 treated as 1)
- issue_even_valid  out  1  issue to the even pipe this cycle
- issue_even_sel  out  1  slot issued to even (0/1)
- issue_odd_valid  out  1  issue to the odd pipe this cycle
- issue_odd_sel  out  1  slot issued to odd (0/1)
- stall  out  1  holding register occupied and nothing issued
REQ-003 All outputs SHALL be combinational from registered state plus flush/pair_valid; there SHALL be no other outputs.

Function
REQ-004 The block SHALL hold the accepted pair (all slot fields) in a holding register; slot 0 is older.
REQ-005 The state machine SHALL have three states: EMPTY (nothing held), PAIR (slots 0 and 1, or only slot 0, pending), SECOND (only slot 1 pending).
REQ-006 The scoreboard SHALL be 128 x 3-bit countdown counters; every nonzero counter decrements by 1 each cycle.
REQ-007 A source is ready iff its srcuse bit is 0 or the counter for that register is 0.
REQ-008 An issued instruction with wen=1 SHALL load the counter for rt with max(L-1, current-1), where L=max(latency,1).
- A dependant therefore issues no earlier than L cycles after its producer.
- L=1 allows back-to-back issue.
REQ-009 In PAIR, slot 0 SHALL issue when all its sources are ready, to the pipe given by slot0_pipe.
REQ-010 Slot 1 SHALL dual-issue in the same cycle only if all of these hold:
- slot 0 issues;
- slot1_valid=1;
- slot1_pipe differs from slot0_pipe;
- slot 1 sources are ready;
- no slot 1 used source equals slot0_rt when slot0_wen=1;
- not (both wen=1 and equal rt).
REQ-011 PAIR transitions:
- both issued, or slot 0 issued with slot1_valid=0 -> EMPTY;
- slot 0 issued alone with slot1_valid=1 -> SECOND;
- slot 0 blocked -> stay in PAIR, and slot 1 SHALL NOT issue (in-order).
REQ-012 In SECOND, slot 1 SHALL issue when its sources are ready (then -> EMPTY); otherwise the state stays SECOND.
REQ-013 pair_ready SHALL be ~flush & (EMPTY | holding register fully drains this cycle); a pair loads when pair_valid & pair_ready, and the next state is PAIR.
REQ-014 When flush=1, the state SHALL go to EMPTY, all issue_* outputs SHALL be 0 that cycle, pair_ready SHALL be 0, and the scoreboard SHALL keep counting (in-flight writes still complete).
REQ-015 stall SHALL be 1 iff the state is not EMPTY, flush=0, and neither issue_* output is 1.
REQ-016 For an issue_* output whose valid is 0, its sel SHALL be 0.

Reset
REQ-017 While reset=0 at a clock edge:
- the state SHALL become EMPTY;
- all 128 counters SHALL become 0;
- the holding register SHALL be cleared.
REQ-018 While reset=0, pair_ready, issue_even_valid, issue_odd_valid, issue_*_sel and stall SHALL all be 0.
REQ-019 In the first cycle after reset is released, pair_ready SHALL be 1 when flush=0.
REQ-020 A reset asserted while in PAIR or SECOND SHALL drop the pending instructions and SHALL NOT issue them.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Independent pair (slot0 even rt=5 L=2, slot1 odd rt=6 L=4, no shared regs) -> both valid in one cycle, odd_sel=1, back to EMPTY, pair_ready=1.
- Same pipe (both even) -> cycle 1: even_valid, sel=0; cycle 2: even_valid, sel=1, state SECOND then EMPTY.
- Intra-pair RAW (slot0 rt=10 L=6, slot1 odd reads RA=10) -> slot 1 issues exactly 6 cycles after slot 0, stall=1 for the 5 cycles between.
- Cross-pair RAW at L=1 (producer rt=3, next pair reads RB=3) -> consumer issues the next cycle, no stall.
- Flush in SECOND with slot 1 blocked -> issue outputs 0, pair_ready=0 that cycle, EMPTY next cycle, counters still decrementing.
- Reset in PAIR with counter[7]=5 -> all outputs 0; after release, a consumer of r7 issues immediately.
